// File: rtl/game_pkg.sv
// Shared types and constants for the guessing-game round controller.
package game_pkg;

    localparam int PEG_W        = 3;
    localparam int NUM_PEGS     = 4;
    localparam int NUM_COLORS   = 8;
    localparam int GRADE_CYCLES = 8;
    localparam int CNT_W        = 3;

    typedef logic [PEG_W-1:0] peg_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_GUESS = 3'd1,
        ST_LOAD_GUESS = 3'd2,
        ST_GRADE      = 3'd3,
        ST_REPORT     = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Smaller of two per-colour occurrence counts: the colour matches shared
    // between guess and master for one colour.
    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        cnt_t r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/guess_round_ctrl_if.sv
// Handshake/data bundle between the user-control side (master) and the
// round controller (slave), including the guess register bank outputs.
interface guess_round_ctrl_if;

    logic        startGame;
    logic [11:0] masterPattern;
    logic        guessValid;
    logic [3:0]  guess0;
    logic [3:0]  guess1;
    logic [3:0]  guess2;
    logic [3:0]  guess3;

    logic        loadGuessNow;
    logic [2:0]  numZnarly;
    logic [2:0]  numZood;
    logic        scoreValid;
    logic [3:0]  roundNum;
    logic        ready;
    logic        gameWon;
    logic        gameOver;

    modport master (
        output startGame, masterPattern, guessValid,
               guess0, guess1, guess2, guess3,
        input  loadGuessNow, numZnarly, numZood, scoreValid,
               roundNum, ready, gameWon, gameOver
    );

    modport slave (
        input  startGame, masterPattern, guessValid,
               guess0, guess1, guess2, guess3,
        output loadGuessNow, numZnarly, numZood, scoreValid,
               roundNum, ready, gameWon, gameOver
    );

endinterface

// File: rtl/peg_count.sv
// Counts how many of four packed pegs carry the given colour (0..4).
module peg_count
    import game_pkg::*;
(
    input  logic [NUM_PEGS*PEG_W-1:0] pegs,
    input  peg_t                      color,
    output cnt_t                      count
);

    cnt_t cnt_s;

    // Tally matching pegs one position at a time.
    always_comb begin
        cnt_s = 3'd0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (pegs[i*PEG_W +: PEG_W] == color) begin
                cnt_s = cnt_s + 3'd1;
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    assign count = cnt_s;

endmodule

// File: rtl/guess_round_ctrl.sv
// Game-round controller: latches the master pattern, requests guess loads,
// grades each guess over a fixed eight-cycle colour sweep, counts rounds and
// flags win / game over. All outputs are registered.
module guess_round_ctrl
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS = 10
)
(
    input  logic              CLOCK_50,
    input  logic              reset,
    guess_round_ctrl_if.slave bus
);

    localparam logic [3:0] MAX_R      = 4'(MAX_ROUNDS);
    localparam peg_t       LAST_COLOR = peg_t'(NUM_COLORS - 1);
    localparam cnt_t       ALL_EXACT  = cnt_t'(NUM_PEGS);

    // State and registers
    state_t      state_r,      state_nxt_s;
    logic [11:0] master_r,     master_nxt_s;
    peg_t        color_r,      color_nxt_s;
    cnt_t        exact_r,      exact_nxt_s;
    cnt_t        common_r,     common_nxt_s;
    logic        load_r,       load_nxt_s;
    cnt_t        znarly_r,     znarly_nxt_s;
    cnt_t        zood_r,       zood_nxt_s;
    logic        sv_r,         sv_nxt_s;
    logic [3:0]  round_r,      round_nxt_s;
    logic        ready_r,      ready_nxt_s;
    logic        won_r,        won_nxt_s;
    logic        over_r,       over_nxt_s;

    // Grading datapath
    logic [11:0] guess_pk_s;
    cnt_t        guess_cnt_s;
    cnt_t        master_cnt_s;
    cnt_t        exact_s;
    cnt_t        common_sum_s;

    assign guess_pk_s = {bus.guess3[2:0], bus.guess2[2:0],
                         bus.guess1[2:0], bus.guess0[2:0]};

    peg_count u_guess_count (
        .pegs  (guess_pk_s),
        .color (color_r),
        .count (guess_cnt_s)
    );

    peg_count u_master_count (
        .pegs  (master_r),
        .color (color_r),
        .count (master_cnt_s)
    );

    // Exact-position matches between the loaded guess and the master.
    always_comb begin
        exact_s = 3'd0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess_pk_s[i*PEG_W +: PEG_W] == master_r[i*PEG_W +: PEG_W]) begin
                exact_s = exact_s + 3'd1;
            end else begin
                exact_s = exact_s;
            end
        end
    end

    // Running colour-match total including the current colour.
    assign common_sum_s = common_r + min_cnt(guess_cnt_s, master_cnt_s);

    // Next-state and next-register decode; startGame overrides everything.
    always_comb begin
        state_nxt_s  = state_r;
        master_nxt_s = master_r;
        color_nxt_s  = color_r;
        exact_nxt_s  = exact_r;
        common_nxt_s = common_r;
        load_nxt_s   = 1'b0;
        znarly_nxt_s = znarly_r;
        zood_nxt_s   = zood_r;
        sv_nxt_s     = 1'b0;
        round_nxt_s  = round_r;
        won_nxt_s    = won_r;
        over_nxt_s   = over_r;

        if (bus.startGame) begin
            state_nxt_s  = ST_WAIT_GUESS;
            master_nxt_s = bus.masterPattern;
            color_nxt_s  = 3'd0;
            exact_nxt_s  = 3'd0;
            common_nxt_s = 3'd0;
            znarly_nxt_s = 3'd0;
            zood_nxt_s   = 3'd0;
            round_nxt_s  = 4'd0;
            won_nxt_s    = 1'b0;
            over_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_WAIT_GUESS: begin
                    if (bus.guessValid) begin
                        state_nxt_s = ST_LOAD_GUESS;
                        load_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_GUESS;
                    end
                end
                ST_LOAD_GUESS: begin
                    state_nxt_s  = ST_GRADE;
                    color_nxt_s  = 3'd0;
                    exact_nxt_s  = 3'd0;
                    common_nxt_s = 3'd0;
                end
                ST_GRADE: begin
                    common_nxt_s = common_sum_s;
                    if (color_r == 3'd0) begin
                        exact_nxt_s = exact_s;
                    end else begin
                        exact_nxt_s = exact_r;
                    end
                    if (color_r == LAST_COLOR) begin
                        // Last colour: publish the score so it is visible in REPORT.
                        state_nxt_s  = ST_REPORT;
                        color_nxt_s  = 3'd0;
                        znarly_nxt_s = exact_r;
                        zood_nxt_s   = common_sum_s - exact_r;
                        sv_nxt_s     = 1'b1;
                        if (round_r < MAX_R) begin
                            round_nxt_s = round_r + 4'd1;
                        end else begin
                            round_nxt_s = round_r;
                        end
                        if (exact_r == ALL_EXACT) begin
                            won_nxt_s  = 1'b1;
                            over_nxt_s = 1'b1;
                        end else if ((round_r + 4'd1) == MAX_R) begin
                            over_nxt_s = 1'b1;
                        end else begin
                            over_nxt_s = over_r;
                        end
                    end else begin
                        state_nxt_s = ST_GRADE;
                        color_nxt_s = color_r + 3'd1;
                    end
                end
                ST_REPORT: begin
                    if (over_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT_GUESS;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        ready_nxt_s = (state_nxt_s == ST_WAIT_GUESS);
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, accumulator and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            master_r <= 12'd0;
            color_r  <= 3'd0;
            exact_r  <= 3'd0;
            common_r <= 3'd0;
            load_r   <= 1'b0;
            znarly_r <= 3'd0;
            zood_r   <= 3'd0;
            sv_r     <= 1'b0;
            round_r  <= 4'd0;
            ready_r  <= 1'b0;
            won_r    <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            master_r <= master_nxt_s;
            color_r  <= color_nxt_s;
            exact_r  <= exact_nxt_s;
            common_r <= common_nxt_s;
            load_r   <= load_nxt_s;
            znarly_r <= znarly_nxt_s;
            zood_r   <= zood_nxt_s;
            sv_r     <= sv_nxt_s;
            round_r  <= round_nxt_s;
            ready_r  <= ready_nxt_s;
            won_r    <= won_nxt_s;
            over_r   <= over_nxt_s;
        end
    end

    assign bus.loadGuessNow = load_r;
    assign bus.numZnarly    = znarly_r;
    assign bus.numZood      = zood_r;
    assign bus.scoreValid   = sv_r;
    assign bus.roundNum     = round_r;
    assign bus.ready        = ready_r;
    assign bus.gameWon      = won_r;
    assign bus.gameOver     = over_r;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Self-checking bench for guess_round_ctrl: directed scenarios plus random
// games, scored against a counting model of the game rules.
module tb_guess_round_ctrl;

    localparam int MAXR = 10;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    guess_round_ctrl_if bus ();

    guess_round_ctrl #(.MAX_ROUNDS(MAXR)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] pending = 12'd0;

    // Guess register bank: loads the pending guess only under loadGuessNow.
    always @(posedge CLOCK_50) begin
        if (!reset) begin
            bus.guess0 <= 4'd0;
            bus.guess1 <= 4'd0;
            bus.guess2 <= 4'd0;
            bus.guess3 <= 4'd0;
        end else if (bus.loadGuessNow) begin
            bus.guess0 <= {1'($urandom_range(0, 1)), pending[2:0]};
            bus.guess1 <= {1'($urandom_range(0, 1)), pending[5:3]};
            bus.guess2 <= {1'($urandom_range(0, 1)), pending[8:6]};
            bus.guess3 <= {1'($urandom_range(0, 1)), pending[11:9]};
        end
    end

    // Reference game state
    logic [11:0] m_master;
    int          m_round;
    bit          m_won;
    bit          m_over;
    bit          m_started;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Score from the rules: exact = same colour same slot; common = per colour
    // min of occurrences; zood = common - exact.
    function automatic void score(input logic [11:0] g, input logic [11:0] m,
                                  output int ex, output int zd);
        int gc [8];
        int mc [8];
        int common;
        ex = 0;
        common = 0;
        for (int k = 0; k < 8; k++) begin
            gc[k] = 0;
            mc[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            int gv;
            int mv;
            gv = int'(g[3*i +: 3]);
            mv = int'(m[3*i +: 3]);
            if (gv == mv) ex++;
            gc[gv]++;
            mc[mv]++;
        end
        for (int k = 0; k < 8; k++) common += (gc[k] < mc[k]) ? gc[k] : mc[k];
        zd = common - ex;
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic start_game(input logic [11:0] mp);
        bus.masterPattern = mp;
        bus.startGame     = 1'b1;
        step();
        bus.startGame     = 1'b0;
        bus.masterPattern = 12'($urandom);
        m_master  = mp;
        m_round   = 0;
        m_won     = 1'b0;
        m_over    = 1'b0;
        m_started = 1'b1;
        check_eq("start_round", 32'(bus.roundNum), 32'd0);
        check_eq("start_ready", 32'(bus.ready), 32'd1);
        check_eq("start_won",   32'(bus.gameWon), 32'd0);
        check_eq("start_over",  32'(bus.gameOver), 32'd0);
        check_eq("start_znarly", 32'(bus.numZnarly), 32'd0);
        check_eq("start_zood",  32'(bus.numZood), 32'd0);
    endtask

    // Submit one guess; extra_at (2..8) pulses guessValid again mid-grade.
    task automatic run_guess(input logic [11:0] gp, input int extra_at);
        bit accept;
        int ex;
        int zd;
        int lat;
        int extra_loads;
        int sv_seen;
        accept = m_started && !m_over;
        pending = gp;
        bus.guessValid = 1'b1;
        step();
        bus.guessValid = 1'b0;
        check_eq("load_pulse", 32'(bus.loadGuessNow), 32'(accept));
        if (accept) begin
            score(gp, m_master, ex, zd);
            lat = 1;
            extra_loads = 0;
            sv_seen = 0;
            while (sv_seen == 0 && lat < 20) begin
                if (lat == extra_at) bus.guessValid = 1'b1;
                step();
                bus.guessValid = 1'b0;
                lat++;
                extra_loads += int'(bus.loadGuessNow);
                if (bus.scoreValid) sv_seen = 1;
            end
            m_round++;
            if (ex == 4) begin
                m_won  = 1'b1;
                m_over = 1'b1;
            end else if (m_round == MAXR) begin
                m_over = 1'b1;
            end
            check_eq("latency",     32'(lat), 32'd10);
            check_eq("extra_load",  32'(extra_loads), 32'd0);
            check_eq("znarly",      32'(bus.numZnarly), 32'(ex));
            check_eq("zood",        32'(bus.numZood), 32'(zd));
            check_eq("round",       32'(bus.roundNum), 32'(m_round));
            check_eq("won",         32'(bus.gameWon), 32'(m_won));
            check_eq("over",        32'(bus.gameOver), 32'(m_over));
            step();
            check_eq("sv_one_cycle", 32'(bus.scoreValid), 32'd0);
            check_eq("ready_after", 32'(bus.ready), 32'(!m_over));
            check_eq("znarly_hold", 32'(bus.numZnarly), 32'(ex));
        end else begin
            extra_loads = 0;
            sv_seen = 0;
            for (int k = 0; k < 12; k++) begin
                step();
                extra_loads += int'(bus.loadGuessNow);
                sv_seen += int'(bus.scoreValid);
            end
            check_eq("ign_load", 32'(extra_loads), 32'd0);
            check_eq("ign_sv",   32'(sv_seen), 32'd0);
        end
    endtask

    initial begin
        logic [11:0] mp;
        logic [11:0] gp;
        int          guard;

        bus.startGame     = 1'b0;
        bus.masterPattern = 12'd0;
        bus.guessValid    = 1'b0;
        m_master  = 12'd0;
        m_round   = 0;
        m_won     = 1'b0;
        m_over    = 1'b0;
        m_started = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_round", 32'(bus.roundNum), 32'd0);
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_sv",    32'(bus.scoreValid), 32'd0);
        check_eq("rst_over",  32'(bus.gameOver), 32'd0);
        reset = 1'b1;
        step();

        // IDLE ignores guesses before any game
        run_guess(pk(0, 1, 2, 3), 0);

        // Exact win, then further guesses are ignored
        start_game(12'h688);
        run_guess(pk(0, 1, 2, 3), 0);
        run_guess(pk(0, 1, 2, 3), 0);

        // All zood, then reset in the middle of grading
        start_game(pk(0, 1, 2, 3));
        run_guess(pk(1, 0, 3, 2), 0);
        pending = pk(0, 0, 0, 0);
        bus.guessValid = 1'b1;
        step();
        bus.guessValid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b0;
        #1;
        check_eq("arst_load",   32'(bus.loadGuessNow), 32'd0);
        check_eq("arst_znarly", 32'(bus.numZnarly), 32'd0);
        check_eq("arst_zood",   32'(bus.numZood), 32'd0);
        check_eq("arst_sv",     32'(bus.scoreValid), 32'd0);
        check_eq("arst_round",  32'(bus.roundNum), 32'd0);
        check_eq("arst_ready",  32'(bus.ready), 32'd0);
        check_eq("arst_won",    32'(bus.gameWon), 32'd0);
        check_eq("arst_over",   32'(bus.gameOver), 32'd0);
        step();
        step();
        reset = 1'b1;
        m_started = 1'b0;
        run_guess(pk(0, 1, 2, 3), 0);

        // Duplicates
        start_game(pk(0, 1, 2, 3));
        run_guess(pk(0, 0, 0, 0), 0);
        start_game(pk(0, 0, 1, 1));
        run_guess(pk(1, 1, 0, 2), 5);

        // Loss after MAXR misses; the next guess is ignored
        start_game(pk(0, 1, 2, 3));
        for (int r = 0; r < MAXR; r++) run_guess(pk(7, 7, 7, 7), (r % 3 == 0) ? 4 : 0);
        run_guess(pk(7, 7, 7, 7), 0);

        // startGame wins over guessValid in the same cycle
        bus.masterPattern = pk(4, 5, 6, 7);
        bus.startGame  = 1'b1;
        bus.guessValid = 1'b1;
        step();
        bus.startGame  = 1'b0;
        bus.guessValid = 1'b0;
        m_master = pk(4, 5, 6, 7);
        m_round = 0;
        m_won = 1'b0;
        m_over = 1'b0;
        m_started = 1'b1;
        check_eq("prio_load",  32'(bus.loadGuessNow), 32'd0);
        check_eq("prio_round", 32'(bus.roundNum), 32'd0);
        check_eq("prio_ready", 32'(bus.ready), 32'd1);
        step();
        check_eq("prio_noload", 32'(bus.loadGuessNow), 32'd0);
        run_guess(pk(7, 6, 5, 4), 0);

        // Random games
        for (int gidx = 0; gidx < 15; gidx++) begin
            mp = 12'($urandom);
            start_game(mp);
            guard = 0;
            while (!m_over && guard < 20) begin
                if ($urandom_range(0, 5) == 0) begin
                    gp = mp;
                end else if ($urandom_range(0, 1) == 0) begin
                    gp = pk($urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3));
                end else begin
                    gp = 12'($urandom);
                end
                run_guess(gp, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 8) : 0);
                guard++;
            end
            run_guess(12'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
